// File: rtl/idelay_pkg.sv
// rtl/idelay_pkg.sv - shared state encoding and widths for the IDELAY eye scanner
package idelay_pkg;

    localparam int TAP_W    = 9;
    localparam int ERRCNT_W = 16;
    // Run lengths need one more bit than a tap: a step-1 sweep has 512 points.
    localparam int LEN_W    = TAP_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SETTLE,
        DWELL,
        EVAL,
        NEXT,
        APPLY,
        FIN_RDY
    } state_t;

endpackage

// File: rtl/idelay_eye_scan_if.sv
// rtl/idelay_eye_scan_if.sv - delay-controller and pattern-checker signals seen by the scanner
interface idelay_eye_scan_if;
    import idelay_pkg::*;

    logic [TAP_W-1:0] delay_target;
    logic             delay_ready;
    logic             data_valid;
    logic             data_err;

    modport master (
        output delay_target,
        input  delay_ready,
        input  data_valid,
        input  data_err
    );

    modport slave (
        input  delay_target,
        output delay_ready,
        output data_valid,
        output data_err
    );

endinterface

// File: rtl/idelay_eye_run_tracker.sv
// rtl/idelay_eye_run_tracker.sv - tracks current and widest run of passing scan points
module idelay_eye_run_tracker
    import idelay_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_eval,
    input  logic             i_pass,
    input  logic [TAP_W-1:0] i_tap,
    output logic [TAP_W-1:0] o_best_start,
    output logic [LEN_W-1:0] o_best_len
);

    logic [TAP_W-1:0] r_cur_start;
    logic [LEN_W-1:0] r_cur_len;
    logic [TAP_W-1:0] r_best_start;
    logic [LEN_W-1:0] r_best_len;

    logic [LEN_W-1:0] w_new_len;
    logic [TAP_W-1:0] w_run_start;

    assign w_new_len   = r_cur_len + LEN_W'(1);
    assign w_run_start = (r_cur_len == '0) ? i_tap : r_cur_start;

    // Strict greater-than keeps the earlier window on a tie.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_eval) begin
            if (i_pass) begin
                r_cur_start <= w_run_start;
                r_cur_len   <= w_new_len;
                if (w_new_len > r_best_len) begin
                    r_best_start <= w_run_start;
                    r_best_len   <= w_new_len;
                end
            end else begin
                r_cur_len <= '0;
            end
        end
    end

    assign o_best_start = r_best_start;
    assign o_best_len   = r_best_len;

endmodule

// File: rtl/idelay_eye_scan.sv
// rtl/idelay_eye_scan.sv - IDELAY tap sweep, eye search and centring; IDELAY_SCAN_LOG_EN adds a per-point log port
module idelay_eye_scan
    import idelay_pkg::*;
#(
    parameter int TAP_STEP      = 8,
    parameter int MAX_TAP       = 511,
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_WORDS   = 1024,
    parameter int ERR_THRESH    = 0
) (
    input  logic                i_clk160,
    input  logic                i_rst,
    input  logic                i_start,
    idelay_eye_scan_if.master   bus,
    output logic                o_busy,
    output logic                o_done,
    output logic [TAP_W-1:0]    o_best_tap,
    output logic [TAP_W-1:0]    o_eye_width,
    output logic                o_scan_fail
`ifdef IDELAY_SCAN_LOG_EN
    ,
    output logic                o_log_valid,
    output logic [TAP_W-1:0]    o_log_tap,
    output logic [ERRCNT_W-1:0] o_log_errcnt
`endif
);

    localparam int SET_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int WORD_W = (DWELL_WORDS < 2) ? 1 : $clog2(DWELL_WORDS + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TAP_W-1:0]    r_delay_target;
    logic                r_busy;
    logic                r_done;
    logic [TAP_W-1:0]    r_best_tap;
    logic [TAP_W-1:0]    r_eye_width;
    logic                r_scan_fail;
    logic [SET_W-1:0]    r_settle_cnt;
    logic [WORD_W-1:0]   r_word_cnt;
    logic [ERRCNT_W-1:0] r_errcnt;

    logic                w_trk_clear;
    logic                w_trk_eval;
    logic                w_pass;
    logic                w_settle_done;
    logic                w_dwell_last;
    logic [TAP_W:0]      w_next_tap;
    logic                w_step_ok;
    logic [TAP_W-1:0]    w_best_start;
    logic [LEN_W-1:0]    w_best_len;
    logic [15:0]         w_span;
    logic [15:0]         w_centre;

    assign w_pass        = (r_errcnt <= ERRCNT_W'(ERR_THRESH));
    assign w_settle_done = (32'(r_settle_cnt) + 32'd1 >= 32'(SETTLE_CYCLES));
    assign w_dwell_last  = bus.data_valid && (32'(r_word_cnt) + 32'd1 == 32'(DWELL_WORDS));
    assign w_next_tap    = {1'b0, r_delay_target} + (TAP_W + 1)'(TAP_STEP);
    assign w_step_ok     = (w_next_tap <= (TAP_W + 1)'(MAX_TAP));
    assign w_span        = 16'(w_best_len - LEN_W'(1)) * 16'(TAP_STEP);
    assign w_centre      = 16'(w_best_start) + (w_span >> 1);

    idelay_eye_run_tracker u_tracker (
        .i_clk        (i_clk160),
        .i_rst        (i_rst),
        .i_clear      (w_trk_clear),
        .i_eval       (w_trk_eval),
        .i_pass       (w_pass),
        .i_tap        (r_delay_target),
        .o_best_start (w_best_start),
        .o_best_len   (w_best_len)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_trk_clear = 1'b0;
        w_trk_eval  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_trk_clear = 1'b1;
                    w_state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: if (bus.delay_ready) w_state_nxt = SETTLE;
            SETTLE:   if (w_settle_done)   w_state_nxt = DWELL;
            DWELL:    if (w_dwell_last)    w_state_nxt = EVAL;
            EVAL: begin
                w_trk_eval  = 1'b1;
                w_state_nxt = NEXT;
            end
            NEXT:     w_state_nxt = w_step_ok ? WAIT_RDY : APPLY;
            APPLY:    w_state_nxt = FIN_RDY;
            FIN_RDY:  if (bus.delay_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk160) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_delay_target <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_best_tap     <= '0;
            r_eye_width    <= '0;
            r_scan_fail    <= 1'b0;
            r_settle_cnt   <= '0;
            r_word_cnt     <= '0;
            r_errcnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_scan_fail    <= 1'b0;
                        r_delay_target <= '0;
                        r_busy         <= 1'b1;
                        r_settle_cnt   <= '0;
                        r_word_cnt     <= '0;
                        r_errcnt       <= '0;
                    end
                end
                WAIT_RDY: r_settle_cnt <= '0;
                SETTLE:   r_settle_cnt <= r_settle_cnt + SET_W'(1);
                DWELL: begin
                    if (bus.data_valid) begin
                        r_word_cnt <= r_word_cnt + WORD_W'(1);
                        if (bus.data_err && (r_errcnt != '1)) begin
                            r_errcnt <= r_errcnt + ERRCNT_W'(1);
                        end
                    end
                end
                NEXT: begin
                    if (w_step_ok) begin
                        r_delay_target <= w_next_tap[TAP_W-1:0];
                        r_settle_cnt   <= '0;
                        r_word_cnt     <= '0;
                        r_errcnt       <= '0;
                    end
                end
                APPLY: begin
                    if (w_best_len == '0) begin
                        r_scan_fail    <= 1'b1;
                        r_best_tap     <= '0;
                        r_eye_width    <= '0;
                        r_delay_target <= '0;
                    end else begin
                        r_best_tap     <= w_centre[TAP_W-1:0];
                        r_eye_width    <= (w_best_len > LEN_W'(511)) ? TAP_W'(511)
                                                                     : w_best_len[TAP_W-1:0];
                        r_delay_target <= w_centre[TAP_W-1:0];
                    end
                end
                FIN_RDY: begin
                    if (bus.delay_ready) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.delay_target = r_delay_target;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_best_tap       = r_best_tap;
    assign o_eye_width      = r_eye_width;
    assign o_scan_fail      = r_scan_fail;

`ifdef IDELAY_SCAN_LOG_EN
    assign o_log_valid  = (r_state == EVAL);
    assign o_log_tap    = o_log_valid ? r_delay_target : '0;
    assign o_log_errcnt = o_log_valid ? r_errcnt : '0;
`endif

endmodule

// File: tb/tb_idelay_eye_scan.sv
// tb/tb_idelay_eye_scan.sv - directed scoreboard bench for idelay_eye_scan
module tb_idelay_eye_scan;
    import idelay_pkg::*;

    typedef struct packed {
        logic [8:0] tap;
        logic [8:0] width;
        logic       fail;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [8:0] best_tap;
    logic [8:0] eye_width;
    logic       scan_fail;
`ifdef IDELAY_SCAN_LOG_EN
    logic        log_valid;
    logic [8:0]  log_tap;
    logic [15:0] log_errcnt;
`endif

    logic [8:0] applied;
    logic [1:0] lat;
    logic       stall;
    logic [7:0] err_mask;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    idelay_eye_scan_if bus ();

    idelay_eye_scan #(
        .TAP_STEP      (8),
        .MAX_TAP       (63),
        .SETTLE_CYCLES (2),
        .DWELL_WORDS   (4),
        .ERR_THRESH    (0)
    ) dut (
        .i_clk160    (clk),
        .i_rst       (rst),
        .i_start     (start),
        .bus         (bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_best_tap  (best_tap),
        .o_eye_width (eye_width),
        .o_scan_fail (scan_fail)
`ifdef IDELAY_SCAN_LOG_EN
        ,
        .o_log_valid  (log_valid),
        .o_log_tap    (log_tap),
        .o_log_errcnt (log_errcnt)
`endif
    );

    // Delay controller model: applies a new target three cycles after it changes.
    always @(posedge clk) begin
        if (rst) begin
            applied <= '0;
            lat     <= '0;
        end else if (applied != bus.delay_target) begin
            if (lat == 2'd2) begin
                applied <= bus.delay_target;
                lat     <= '0;
            end else begin
                lat <= lat + 2'd1;
            end
        end
    end

    assign bus.delay_ready = (applied == bus.delay_target) && !stall;
    assign bus.data_valid  = 1'b1;
    assign bus.data_err    = err_mask[applied[5:3]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Brute force over every window: longest all-pass span, earliest on a tie.
    function automatic exp_t model(input logic [7:0] m);
        exp_t r;
        int   bl = 0;
        int   bs = 0;
        bit   ok;
        for (int s = 0; s < 8; s++) begin
            for (int e = s; e < 8; e++) begin
                ok = 1'b1;
                for (int k = s; k <= e; k++) if (m[k]) ok = 1'b0;
                if (ok && (e - s + 1) > bl) begin
                    bl = e - s + 1;
                    bs = s;
                end
            end
        end
        if (bl == 0) begin
            r.tap = '0; r.width = '0; r.fail = 1'b1;
        end else begin
            r.tap = 9'(bs * 8 + ((bl - 1) * 8) / 2); r.width = 9'(bl); r.fail = 1'b0;
        end
        return r;
    endfunction

    task automatic run_scan(input logic [7:0] mask, input bit stall_en, input bit extra_start,
                            output int cyc);
        exp_t e;
        int   nd;
        bit   stalled;
        bit   hold_ok;
        err_mask = mask;
        sb.push_back(model(mask));
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 16'(busy), 16'd1);
        check("target0_after_start", 16'(bus.delay_target), 16'd0);
        cyc     = 0;
        nd      = 0;
        stalled = 1'b0;
        while (nd == 0 && cyc < 3000) begin
            start = extra_start && (cyc == 5 || cyc == 40);
            if (stall_en && !stalled && bus.delay_target == 9'd16) begin
                stalled = 1'b1;
                stall   = 1'b1;
                start   = 1'b0;
                hold_ok = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    step();
                    cyc++;
                    if (bus.delay_target != 9'd16 || done || !busy) hold_ok = 1'b0;
                end
                check("stall_hold", 16'(hold_ok), 16'd1);
                stall = 1'b0;
            end
            step();
            cyc++;
            if (done) nd++;
        end
        start = 1'b0;
        check("done_seen", 16'(nd), 16'd1);
        if (nd != 0 && sb.size() != 0) begin
            e = sb.pop_front();
            check("best_tap", 16'(best_tap), 16'(e.tap));
            check("eye_width", 16'(eye_width), 16'(e.width));
            check("scan_fail", 16'(scan_fail), 16'(e.fail));
            check("final_target", 16'(bus.delay_target), 16'(e.tap));
            check("busy_at_done", 16'(busy), 16'd0);
        end
        repeat (4) begin
            step();
            if (done) nd++;
        end
        check("done_once", 16'(nd), 16'd1);
    endtask

    initial begin
        int len_a;
        int len_b;
        int t;
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        err_mask = '0;
        repeat (3) step();
        check("rst_target", 16'(bus.delay_target), 16'd0);
        check("rst_best_tap", 16'(best_tap), 16'd0);
        check("rst_eye_width", 16'(eye_width), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_scan_fail", 16'(scan_fail), 16'd0);

        // start together with rst is dropped
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("start_rst_busy", 16'(busy), 16'd0);

        run_scan(8'b1000_0011, 1'b0, 1'b0, len_a);
        run_scan(8'hFF,        1'b0, 1'b0, len_a);
        run_scan(8'b1100_1001, 1'b0, 1'b0, len_a);
        run_scan(8'b1000_0011, 1'b1, 1'b0, len_a);

        // reset in the middle of the dwell at tap 24
        err_mask = 8'b1000_0011;
        start    = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (bus.delay_target != 9'd24 && t < 1000) begin step(); t++; end
        check("reach_tap24", 16'(bus.delay_target), 16'd24);
        t = 0;
        while (!bus.delay_ready && t < 100) begin step(); t++; end
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_target", 16'(bus.delay_target), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_best_tap", 16'(best_tap), 16'd0);
        check("midrst_eye_width", 16'(eye_width), 16'd0);
        check("midrst_scan_fail", 16'(scan_fail), 16'd0);
        run_scan(8'b1000_0011, 1'b0, 1'b0, len_a);

        // extra starts while busy must not change the result or the scan length
        run_scan(8'b1000_0011, 1'b0, 1'b0, len_a);
        run_scan(8'b1000_0011, 1'b0, 1'b1, len_b);
        check("scan_len_extra_start", 16'(len_b), 16'(len_a));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/idelay_eye_scan.md
Name: idelay_eye_scan

Overview:
- Drives the `delay_target` side of the per-lane IDELAY tap-setting controller.
- On request, sweeps the target tap across the delay range in fixed steps. At each tap it waits for the controller to report `delay_ready`, then counts data errors over a dwell window.
- Finds the widest contiguous error-free window and parks the delay at its centre.
- Sits in the `clk160` domain between the lane's pattern checker and the IDELAY set controller.

Parameters:
- `TAP_STEP`, 8: tap increment between scan points. Legal range 1..64.
- `MAX_TAP`, 511: highest tap the sweep may reach. Must be at most 511.
- `SETTLE_CYCLES`, 16: cycles waited after `delay_ready` before counting, so the data pipeline flushes.
- `DWELL_WORDS`, 1024: number of `data_valid` words counted per scan point.
- `ERR_THRESH`, 0: a scan point passes when its error count is at most this value.

Ports:
- `clk160`: in, 1. Sole clock.
- `rst`: in, 1. Synchronous, active-high reset.
- `start`: in, 1. Single-cycle pulse that begins a scan. Ignored while `busy`.
- `delay_target`: out, 9. Tap requested from the IDELAY set controller.
- `delay_ready`: in, 1. High when the applied delay equals `delay_target`.
- `data_valid`: in, 1. Qualifies `data_err` for one word.
- `data_err`: in, 1. High when the qualified word mismatched the expected pattern.
- `busy`: out, 1. High from the cycle after an accepted `start` until `done`.
- `done`: out, 1. One-cycle pulse when the scan completes and the final tap is applied.
- `best_tap`: out, 9. Centre of the widest passing window.
- `eye_width`: out, 9. Number of consecutive passing scan points in that window.
- `scan_fail`: out, 1. High when no scan point passed.

Behaviour:
- Reset values: `delay_target`, `best_tap`, `eye_width` = 0; `busy`, `done`, `scan_fail` = 0; FSM in IDLE; all counters 0.
- IDLE:
  - On `start`: clear the run trackers and `scan_fail`, set `delay_target` = 0, assert `busy`, go to WAIT_RDY.
- WAIT_RDY:
  - Stay until `delay_ready` = 1, sampled at the earliest one cycle after `delay_target` changes.
  - No timeout; only `rst` exits a stalled wait.
  - Then go to SETTLE.
- SETTLE:
  - Count `SETTLE_CYCLES` cycles, then go to DWELL.
  - `data_valid` is ignored while in SETTLE.
- DWELL:
  - Each `data_valid` increments the word count.
  - Each `data_valid && data_err` increments a 16-bit error count that saturates at 0xFFFF.
  - When the word count reaches `DWELL_WORDS`, go to EVAL. The last word is counted in the cycle it arrives.
- EVAL (one cycle), with pass = (errcnt ≤ `ERR_THRESH`):
  - On pass: if `cur_len` = 0, set `cur_start` = current tap; then `cur_len`++.
  - On pass, if the new `cur_len` is strictly greater than `best_len`: `best_start` = `cur_start`, `best_len` = `cur_len`. Ties keep the earlier window.
  - On fail: `cur_len` = 0.
  - Go to NEXT.
- NEXT:
  - If `delay_target` + `TAP_STEP` ≤ `MAX_TAP`: add `TAP_STEP` (computed at 10 bits, no wrap), clear the counters, go to WAIT_RDY.
  - Otherwise go to APPLY.
- APPLY:
  - If `best_len` = 0: `scan_fail` = 1, `best_tap` = 0, `eye_width` = 0, `delay_target` = 0.
  - Otherwise: `best_tap` = `best_start` + ((`best_len` − 1) × `TAP_STEP`) / 2, with floor division. `eye_width` = `best_len`, and `delay_target` = `best_tap`.
  - Go to FIN_RDY.
- FIN_RDY:
  - Wait for `delay_ready`, then pulse `done` for one cycle, drop `busy`, return to IDLE.
- Results:
  - `best_tap`, `eye_width` and `scan_fail` hold until the next accepted `start` or `rst`.
  - `delay_target` holds after completion.
- Boundary conditions:
  - `start` coincident with `rst`: `rst` wins.
  - `rst` mid-scan: everything returns to reset values, including `delay_target` = 0.
  - `MAX_TAP` < `TAP_STEP`: a single scan point at tap 0.
  - A window that touches the last scan point is closed at APPLY.

Optional Feature:
- Macro: `IDELAY_SCAN_LOG_EN`.
- When defined, three outputs are added: `log_valid` (1), `log_tap` (9) and `log_errcnt` (16).
  - `log_valid` pulses in the EVAL cycle with the current tap and its saturated error count.
  - All three reset to 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `idelay_pkg`:
  - FSM state enum: IDLE, WAIT_RDY, SETTLE, DWELL, EVAL, NEXT, APPLY, FIN_RDY.
  - `TAP_W` = 9.
  - `ERRCNT_W` = 16.
- Sub-module `idelay_eye_run_tracker`:
  - Holds `cur_start`, `cur_len`, `best_start` and `best_len`.
  - Inputs: clear, eval strobe, pass, tap.
  - Keeps the EVAL arithmetic out of the FSM file.

Test Plan (all scenarios use `TAP_STEP`=8, `MAX_TAP`=63, `DWELL_WORDS`=4, `SETTLE_CYCLES`=2, `ERR_THRESH`=0, with `data_valid` always high):
- Errors only at taps 0, 8 and 56 → `best_tap`=32, `eye_width`=5, `scan_fail`=0, final `delay_target`=32.
- `data_err` always 1 → `scan_fail`=1, `best_tap`=0, `eye_width`=0, `done` pulses once.
- Passing taps 8 and 16, fail at 24, passing 32 and 40 → tie resolves to the first window: `best_tap`=12, `eye_width`=2.
- `delay_ready` held low for 50 cycles at tap 16 → FSM stays in WAIT_RDY, no DWELL counting, and the scan resumes and completes correctly once `delay_ready` rises.
- `rst` asserted during DWELL at tap 24 → next cycle all outputs are at reset values; a subsequent `start` restarts from tap 0.
- `start` pulsed while `busy` → ignored: result and scan length are identical to a single-start run.
